// File: rtl/spi_flash_seq.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_seq
// Purpose  : Turns page-write / page-read requests into SPI flash engine
//            command sequences (WREN, PROGRAM, status poll / READ).
// Revision : 1.0
// ============================================================================
module spi_flash_seq #(
    parameter int POLL_GAP  = 16,
    parameter int MAX_POLLS = 1000,
    parameter int CMD_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_req,
    input  logic             rd_req,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CMD_W-1:0] eng_cmd,
    output logic             eng_enable,
    input  logic             eng_busy,
    input  logic             eng_done,
    input  logic [7:0]       eng_status
);

    localparam logic [CMD_W-1:0] c_CMD_IDLE = CMD_W'(0);
    localparam logic [CMD_W-1:0] c_CMD_WREN = CMD_W'(1);
    localparam logic [CMD_W-1:0] c_CMD_STAT = CMD_W'(2);
    localparam logic [CMD_W-1:0] c_CMD_PROG = CMD_W'(3);
    localparam logic [CMD_W-1:0] c_CMD_READ = CMD_W'(4);

    localparam logic [15:0] c_MAX_POLLS = 16'(MAX_POLLS);
    // The POLL state itself supplies the final idle cycle of the gap, so GAP
    // runs POLL_GAP-1 cycles (and is skipped entirely when POLL_GAP is 1).
    localparam logic [7:0]  c_GAP_LAST  = 8'((POLL_GAP > 1) ? (POLL_GAP - 2) : 0);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_WREN   = 4'd1,
        S_WREN_W = 4'd2,
        S_PROG   = 4'd3,
        S_PROG_W = 4'd4,
        S_POLL   = 4'd5,
        S_POLL_W = 4'd6,
        S_GAP    = 4'd7,
        S_READ   = 4'd8,
        S_READ_W = 4'd9,
        S_FIN    = 4'd10
    } state_t;

    state_t           r_state, w_state_n;
    logic             r_busy, w_busy_n;
    logic             r_done, w_done_n;
    logic             r_timeout, w_timeout_n;
    logic             r_en, w_en_n;
    logic [CMD_W-1:0] r_cmd, w_cmd_n;
    logic [15:0]      r_poll, w_poll_n, w_poll_inc;
    logic [7:0]       r_gap, w_gap_n;
    logic             w_unused_status;

    assign w_unused_status = ^eng_status[7:1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_en      <= 1'b0;
            r_cmd     <= c_CMD_IDLE;
            r_poll    <= 16'd0;
            r_gap     <= 8'd0;
        end else begin
            r_state   <= w_state_n;
            r_busy    <= w_busy_n;
            r_done    <= w_done_n;
            r_timeout <= w_timeout_n;
            r_en      <= w_en_n;
            r_cmd     <= w_cmd_n;
            r_poll    <= w_poll_n;
            r_gap     <= w_gap_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_busy_n    = r_busy;
        w_done_n    = 1'b0;
        w_timeout_n = r_timeout;
        w_en_n      = 1'b0;
        w_cmd_n     = r_cmd;
        w_poll_n    = r_poll;
        w_gap_n     = r_gap;
        w_poll_inc  = r_poll + 16'd1;

        unique case (r_state)
            S_IDLE: begin
                w_cmd_n = c_CMD_IDLE;
                if (wr_req) begin
                    w_state_n   = S_WREN;
                    w_busy_n    = 1'b1;
                    w_timeout_n = 1'b0;
                end else if (rd_req) begin
                    w_state_n   = S_READ;
                    w_busy_n    = 1'b1;
                    w_timeout_n = 1'b0;
                end
            end
            S_WREN: begin
                if (!eng_busy) begin
                    w_en_n    = 1'b1;
                    w_cmd_n   = c_CMD_WREN;
                    w_state_n = S_WREN_W;
                end
            end
            S_WREN_W: begin
                if (eng_done) begin
                    w_state_n = S_PROG;
                end
            end
            S_PROG: begin
                if (!eng_busy) begin
                    w_en_n    = 1'b1;
                    w_cmd_n   = c_CMD_PROG;
                    w_state_n = S_PROG_W;
                end
            end
            S_PROG_W: begin
                if (eng_done) begin
                    w_poll_n  = 16'd0;
                    w_state_n = S_POLL;
                end
            end
            S_POLL: begin
                if (!eng_busy) begin
                    w_en_n    = 1'b1;
                    w_cmd_n   = c_CMD_STAT;
                    w_state_n = S_POLL_W;
                end
            end
            S_POLL_W: begin
                if (eng_done) begin
                    w_poll_n = w_poll_inc;
                    if (!eng_status[0]) begin
                        w_state_n   = S_FIN;
                        w_done_n    = 1'b1;
                        w_busy_n    = 1'b0;
                        w_timeout_n = 1'b0;
                    end else if (w_poll_inc == c_MAX_POLLS) begin
                        w_state_n   = S_FIN;
                        w_done_n    = 1'b1;
                        w_busy_n    = 1'b0;
                        w_timeout_n = 1'b1;
                    end else begin
                        w_gap_n   = 8'd0;
                        w_state_n = (POLL_GAP > 1) ? S_GAP : S_POLL;
                    end
                end
            end
            S_GAP: begin
                if (r_gap == c_GAP_LAST) begin
                    w_state_n = S_POLL;
                end else begin
                    w_gap_n = r_gap + 8'd1;
                end
            end
            S_READ: begin
                if (!eng_busy) begin
                    w_en_n    = 1'b1;
                    w_cmd_n   = c_CMD_READ;
                    w_state_n = S_READ_W;
                end
            end
            S_READ_W: begin
                if (eng_done) begin
                    w_state_n   = S_FIN;
                    w_done_n    = 1'b1;
                    w_busy_n    = 1'b0;
                    w_timeout_n = 1'b0;
                end
            end
            S_FIN: begin
                w_state_n = S_IDLE;
                w_cmd_n   = c_CMD_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
                w_busy_n  = 1'b0;
                w_cmd_n   = c_CMD_IDLE;
            end
        endcase
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign eng_cmd    = r_cmd;
    assign eng_enable = r_en;

endmodule
`default_nettype wire

// File: doc/spi_flash_seq.md
Name: spi_flash_seq

Overview:
- Command sequencer that sits between the user logic and the SPI flash command engine.
- The SPI flash command engine is the block taking a 3-bit command plus an enable strobe.
- It turns a single page-write or page-read request into the correct engine command sequence:
  - write: WRITE_CMD (write enable), then WR_DATA (page program), then RD_STATUS polled until WIP=0;
  - read: RD_DATA.
- It reports completion and timeout back to the requester.

Parameters:
- POLL_GAP, 16, idle clk cycles between the end of one RD_STATUS and the next status issue (1..255).
- MAX_POLLS, 1000, number of RD_STATUS polls after which a still-busy flash is declared timed out (1..65535).
- CMD_W, 3, engine command width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-low (rst=0 resets on the next clk edge)
- wr_req  in  1  single-cycle request: write enable + page program + poll
- rd_req  in  1  single-cycle request: page read
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when a sequence finishes
- timeout  out  1  valid with done; 1 = WIP still set after MAX_POLLS polls
- eng_cmd  out  CMD_W  engine command: IDLE=000, WRITE_CMD=001, RD_STATUS=010, WR_DATA=011, RD_DATA=100
- eng_enable  out  1  one-cycle command strobe to engine
- eng_busy  in  1  engine executing a command
- eng_done  in  1  one-cycle pulse when engine finishes current command
- eng_status  in  8  flash status byte, valid in the eng_done cycle of RD_STATUS; bit0 = WIP

Behaviour:
- Reset (rst=0 at a clk edge), all registered:
  - state=IDLE; busy=0; done=0; timeout=0; eng_enable=0; eng_cmd=000;
  - poll and gap counters cleared.
- Reset mid-sequence: abandon immediately and return to IDLE. No done pulse; the engine is not notified.
- All outputs are registered.
- States: IDLE, WREN, WREN_W, PROG, PROG_W, POLL, POLL_W, GAP, READ, READ_W, FIN.
- IDLE: request acceptance.
  - A request sampled high at edge k moves to WREN (wr_req) or READ (rd_req).
  - busy=1 from cycle k+1 onward.
  - wr_req and rd_req high together: write wins; rd_req is dropped, not queued.
  - Requests while busy=1 are ignored.
- Issue states (WREN, PROG, POLL, READ):
  - Wait until eng_busy=0.
  - Then drive eng_cmd=code and eng_enable=1 for exactly one cycle.
  - Go to the matching _W state.
  - eng_cmd holds its value until the next issue; it returns to 000 only in IDLE.
- Wait states (_W): wait for eng_done=1.
  - WREN_W -> PROG.
  - PROG_W -> POLL, with poll counter cleared.
  - READ_W -> FIN, timeout=0.
  - POLL_W, on eng_done:
    - increment poll counter;
    - eng_status[0]=0 -> FIN, timeout=0;
    - else if poll counter = MAX_POLLS -> FIN, timeout=1;
    - else -> GAP.
- GAP: count POLL_GAP cycles, then -> POLL.
- Next-command timing: the next command is issued no earlier than the cycle after eng_done is observed.
- eng_done filtering: eng_done outside a _W state is ignored and has no effect.
- FIN: done=1 and busy=0 in the same cycle, timeout valid, then -> IDLE.
  - timeout holds its value until the next accepted request clears it.
- Minimum request-to-request spacing: a new request is accepted the cycle after FIN.
- Counter widths: poll counter 16 bits; gap counter 8 bits. No wrap; compares use equality with the parameter.

Test Plan:
- Reset hold: rst=0 for 3 cycles with wr_req=1 -> busy=0, eng_enable=0, eng_cmd=000, done=0 throughout.
- Write, flash ready on 3rd poll:
  - Stimulus: wr_req pulse; model eng_done 4 cycles after each enable; status 0x03, 0x01, 0x00.
  - Response: eng_cmd sequence 001, 011, 010, 010, 010, each with a single eng_enable pulse; 16 idle cycles between polls.
  - Completion: done=1 once with timeout=0; busy falls with done.
- Read: rd_req pulse -> single eng_enable with eng_cmd=100; done the cycle after eng_done+1, timeout=0.
- Timeout: MAX_POLLS=4, status always 0x01 -> exactly 4 RD_STATUS issues, then done=1, timeout=1.
- Arbitration / overlap:
  - wr_req and rd_req in the same cycle -> write sequence only.
  - rd_req during PROG_W -> ignored; no extra RD_DATA issued.
- Reset mid-poll: rst=0 during GAP -> next cycle state IDLE, busy=0, no done pulse. A subsequent rd_req completes normally.
